tt_sweep_checker: RTL and testbench

TT_SWEEP_CHECKER -- requirements
Module: tt_sweep_checker

---
 rtl/tt_sweep_pkg.sv | 31 +++
 rtl/tt_popcount.sv | 19 +
 rtl/tt_sweep_checker.sv | 140 ++++++++++++++
 tb/tb_tt_sweep_checker.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
// rtl/tt_sweep_pkg.sv - shared state enum and width helpers for the truth-table sweep checker
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Received-response counter must hold the value 2^pi_w itself
    function automatic int rcv_w(input int pi_w);
        return pi_w + 1;
    endfunction

    // Width of a per-vector popcount over po_w bits
    function automatic int pc_w(input int po_w);
        return $clog2(po_w + 1);
    endfunction

    // Worst case: every one of 2^pi_w vectors differs in all po_w bits
    function automatic int ham_w(input int pi_w, input int po_w);
        return pi_w + $clog2(po_w + 1);
    endfunction

    // Worst case: 2^pi_w vectors each contributing up to 2^po_w-1
    function automatic int abs_w(input int pi_w, input int po_w);
        return pi_w + po_w;
    endfunction

endpackage

// File: rtl/tt_popcount.sv
// rtl/tt_popcount.sv - combinational count of set bits in a W-bit word
module tt_popcount #(
    parameter int W = 5
) (
    input  logic [W-1:0]             in_bits,
    output logic [$clog2(W+1)-1:0]   count
);

    localparam int CW = $clog2(W + 1);

    // Ripple sum of the individual bits; W is small so a linear chain is fine
    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(in_bits[i]);
        end
    end

endmodule

// File: rtl/tt_sweep_checker.sv
// rtl/tt_sweep_checker.sv - exhaustive input sweep with exact/approx response error accumulation (abs-error path under TT_SWEEP_ABS_EN)
module tt_sweep_checker
    import tt_sweep_pkg::*;
#(
    parameter int PI_W = 8,
    parameter int PO_W = 5
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               hold,
    output logic [PI_W-1:0]                    pi_o,
    output logic                               pi_valid,
    input  logic                               po_valid,
    input  logic [PO_W-1:0]                    po_exact,
    input  logic [PO_W-1:0]                    po_approx,
    output logic                               busy,
    output logic                               done,
    output logic [rcv_w(PI_W)-1:0]             err_count,
    output logic [ham_w(PI_W, PO_W)-1:0]       ham_sum,
    output logic [PO_W-1:0]                    max_abs_err,
    output logic [abs_w(PI_W, PO_W)-1:0]       abs_sum
);

    localparam int RCV_W = rcv_w(PI_W);
    localparam int HAM_W = ham_w(PI_W, PO_W);
    localparam int PC_W  = pc_w(PO_W);

    localparam logic [PI_W-1:0]  LAST_VEC = '1;
    localparam logic [RCV_W-1:0] LAST_RSP = {1'b0, LAST_VEC};

    state_t             state;
    logic [RCV_W-1:0]   rcv_cnt;
    logic               start_ok;
    logic               accept;
    logic [PO_W-1:0]    mismatch;
    logic [PC_W-1:0]    ham_term;

    // A new sweep may only be launched from a quiescent state
    assign start_ok = start && (state == IDLE || state == DONE);

    // Responses count only while a sweep or its drain is in flight
    assign accept   = po_valid && (state == SWEEP || state == DRAIN);

    // Vector is offered whenever sweeping and not paused; pi_o itself is registered
    assign pi_valid = (state == SWEEP) && !hold;

    assign mismatch = po_exact ^ po_approx;

    tt_popcount #(
        .W (PO_W)
    ) u_popcount (
        .in_bits (mismatch),
        .count   (ham_term)
    );

    // Sequencer: vector issue, response counting and state transitions
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pi_o    <= '0;
            rcv_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= SWEEP;
                        pi_o    <= '0;
                        rcv_cnt <= '0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                SWEEP, DRAIN: begin
                    if (accept) begin
                        rcv_cnt <= rcv_cnt + 1'b1;
                    end
                    // Final response wins over the last-issue transition (zero-latency responders)
                    if (accept && rcv_cnt == LAST_RSP) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (state == SWEEP && !hold && pi_o == LAST_VEC) begin
                        state <= DRAIN;
                    end
                    // pi_o parks on the last vector instead of wrapping
                    if (state == SWEEP && !hold && pi_o != LAST_VEC) begin
                        pi_o <= pi_o + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Mismatch count and Hamming-distance accumulation, cleared on reset or sweep launch
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            err_count <= '0;
            ham_sum   <= '0;
        end else if (accept) begin
            err_count <= err_count + RCV_W'(mismatch != '0);
            ham_sum   <= ham_sum + HAM_W'(ham_term);
        end
    end

`ifdef TT_SWEEP_ABS_EN
    localparam int ABS_W = abs_w(PI_W, PO_W);

    logic [PO_W-1:0] abs_diff;

    // Unsigned magnitude of the difference without a widened subtractor
    always_comb begin
        abs_diff = (po_exact >= po_approx) ? (po_exact - po_approx) : (po_approx - po_exact);
    end

    // Peak and summed absolute error, cleared alongside the other accumulators
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            max_abs_err <= '0;
            abs_sum     <= '0;
        end else if (accept) begin
            if (abs_diff > max_abs_err) begin
                max_abs_err <= abs_diff;
            end
            abs_sum <= abs_sum + ABS_W'(abs_diff);
        end
    end
`else
    assign max_abs_err = '0;
    assign abs_sum     = '0;
`endif

endmodule

// File: tb/tb_tt_sweep_checker.sv
// tb/tb_tt_sweep_checker.sv - self-checking bench for tt_sweep_checker with a 3-cycle response model
module tb_tt_sweep_checker;

    localparam int PI_W = 8;
    localparam int PO_W = 5;
    localparam int NV   = 256;

`ifdef TT_SWEEP_ABS_EN
    localparam bit ABS_ON = 1'b1;
`else
    localparam bit ABS_ON = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              start;
    logic              hold;
    logic [PI_W-1:0]   pi_o;
    logic              pi_valid;
    logic              po_valid;
    logic [PO_W-1:0]   po_exact;
    logic [PO_W-1:0]   po_approx;
    logic              busy;
    logic              done;
    logic [PI_W:0]     err_count;
    logic [PI_W+2:0]   ham_sum;
    logic [PO_W-1:0]   max_abs_err;
    logic [PI_W+PO_W-1:0] abs_sum;

    tt_sweep_checker #(
        .PI_W (PI_W),
        .PO_W (PO_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .hold        (hold),
        .pi_o        (pi_o),
        .pi_valid    (pi_valid),
        .po_valid    (po_valid),
        .po_exact    (po_exact),
        .po_approx   (po_approx),
        .busy        (busy),
        .done        (done),
        .err_count   (err_count),
        .ham_sum     (ham_sum),
        .max_abs_err (max_abs_err),
        .abs_sum     (abs_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    mode;
        int    hold_at;
        int    start_at;
        int    rand_hold;
        int    e_err;
        int    e_ham;
        int    e_max;
        int    e_abs;
    } vec_t;

    int           total = 0;
    int           bad   = 0;
    logic [4:0]   mask [NV];
    bit           junk = 1'b0;
    int           issued = 0;
    int           order_err = 0;
    logic [PI_W:0] pipe [3];

    function automatic logic [4:0] gold(input int v);
        return 5'((v * 7 + 3) % 32);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_mask(input int mode);
        for (int v = 0; v < NV; v++) begin
            case (mode)
                0: mask[v] = 5'd0;
                1: mask[v] = 5'd1;
                2: mask[v] = (v == 8'h80) ? 5'd16 : 5'd0;
                default: mask[v] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            endcase
        end
    endtask

    // Expected totals straight from the definition, summed over every vector
    task automatic model(output int m_err, output int m_ham, output int m_max, output int m_abs);
        int e, a, d;
        m_err = 0; m_ham = 0; m_max = 0; m_abs = 0;
        for (int v = 0; v < NV; v++) begin
            e = int'(gold(v));
            a = int'(gold(v) ^ mask[v]);
            d = (e > a) ? e - a : a - e;
            if (e != a) m_err++;
            m_ham += $countones(e ^ a);
            if (d > m_max) m_max = d;
            m_abs += d;
        end
        if (!ABS_ON) begin
            m_max = 0;
            m_abs = 0;
        end
    endtask

    // Responder: captures each issued vector and answers it three cycles later
    initial begin
        logic            cv;
        logic [PI_W-1:0] cd;
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        po_valid  = 1'b0;
        po_exact  = '0;
        po_approx = '0;
        forever begin
            @(posedge clk);
            cv = pi_valid;
            cd = pi_o;
            if (cv) begin
                if (int'(cd) != issued) order_err++;
                issued++;
            end
            @(negedge clk);
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = {cv, cd};
            if (junk) begin
                po_valid  = 1'b1;
                po_exact  = 5'd0;
                po_approx = 5'd31;
            end else begin
                po_valid  = pipe[2][PI_W];
                po_exact  = gold(int'(pipe[2][PI_W-1:0]));
                po_approx = gold(int'(pipe[2][PI_W-1:0])) ^ mask[pipe[2][PI_W-1:0]];
            end
        end
    end

    task automatic run_sweep(input string nm, input int hold_at, input int start_at,
                             input int rand_hold, input int t_err, input int t_ham,
                             input int t_max, input int t_abs);
        int cyc, hold_bad, m_err, m_ham, m_max, m_abs, x_err, x_ham, x_max, x_abs;
        bit held, pulsed;
        issued = 0;
        order_err = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({nm, " busy_after_start"}, {busy, done}, 2'b10);
        cyc = 0; hold_bad = 0; held = 0; pulsed = 0;
        while (!done && cyc < 3000) begin
            if (hold_at >= 0 && !held && busy && int'(pi_o) == hold_at) begin
                hold = 1'b1;
                held = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    cyc++;
                    if (int'(pi_o) != hold_at || pi_valid) hold_bad++;
                end
                hold = 1'b0;
            end else if (start_at >= 0 && !pulsed && int'(pi_o) == start_at) begin
                start = 1'b1;
                pulsed = 1'b1;
            end else if (rand_hold != 0) begin
                hold = ($urandom_range(0, 3) == 0);
            end
            @(negedge clk);
            cyc++;
            start = 1'b0;
        end
        hold = 1'b0;
        check({nm, " done"}, done, 1);
        check({nm, " busy_at_done"}, busy, 0);
        check({nm, " issued"}, issued, NV);
        check({nm, " issue_order"}, order_err, 0);
        if (hold_at >= 0) begin
            check({nm, " hold_seen"}, held, 1);
            check({nm, " hold_stall"}, hold_bad, 0);
        end
        model(m_err, m_ham, m_max, m_abs);
        x_err = (t_err >= 0) ? t_err : m_err;
        x_ham = (t_ham >= 0) ? t_ham : m_ham;
        x_max = (t_max >= 0) ? (ABS_ON ? t_max : 0) : m_max;
        x_abs = (t_abs >= 0) ? (ABS_ON ? t_abs : 0) : m_abs;
        check({nm, " err_count"}, err_count, x_err);
        check({nm, " ham_sum"}, ham_sum, x_ham);
        check({nm, " max_abs_err"}, max_abs_err, x_max);
        check({nm, " abs_sum"}, abs_sum, x_abs);
        // Junk responses in DONE must not disturb the held results
        junk = 1'b1;
        repeat (5) @(negedge clk);
        junk = 1'b0;
        check({nm, " done_hold"}, done, 1);
        check({nm, " err_stable"}, err_count, x_err);
        check({nm, " ham_stable"}, ham_sum, x_ham);
        check({nm, " abs_stable"}, abs_sum, x_abs);
    endtask

    task automatic check_zero(input string nm);
        check({nm, " pi_o"}, pi_o, 0);
        check({nm, " pi_valid"}, pi_valid, 0);
        check({nm, " busy"}, busy, 0);
        check({nm, " done"}, done, 0);
        check({nm, " err_count"}, err_count, 0);
        check({nm, " ham_sum"}, ham_sum, 0);
        check({nm, " max_abs_err"}, max_abs_err, 0);
        check({nm, " abs_sum"}, abs_sum, 0);
    endtask

    vec_t tab [7];

    initial begin
        int cyc;
        tab[0] = '{"equal",      0,  -1, -1, 0,   0,   0,   0,   0};
        tab[1] = '{"xor1",       1,  -1, -1, 0, 256, 256,   1, 256};
        tab[2] = '{"single80",   2,  -1, -1, 0,   1,   1,  16,  16};
        tab[3] = '{"hold100",    1, 100, -1, 0, 256, 256,   1, 256};
        tab[4] = '{"start50",    2,  -1, 50, 0,   1,   1,  16,  16};
        tab[5] = '{"rand_a",     3,  -1, -1, 1,  -1,  -1,  -1,  -1};
        tab[6] = '{"rand_b",     3,  -1, -1, 1,  -1,  -1,  -1,  -1};

        rst = 1'b1; start = 1'b0; hold = 1'b0;
        set_mask(0);
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Responses in IDLE are ignored
        junk = 1'b1;
        repeat (4) @(negedge clk);
        junk = 1'b0;
        repeat (4) @(negedge clk);
        check_zero("idle_junk");

        for (int i = 0; i < 7; i++) begin
            set_mask(tab[i].mode);
            run_sweep(tab[i].name, tab[i].hold_at, tab[i].start_at, tab[i].rand_hold,
                      tab[i].e_err, tab[i].e_ham, tab[i].e_max, tab[i].e_abs);
        end

        // Reset in the middle of a sweep, then a clean full sweep
        set_mask(1);
        issued = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 0;
        while (int'(pi_o) != 100 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_reach_100", pi_o, 100);
        check("mid_err_nonzero", (err_count != 0), 1);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check_zero("mid_rst");
        repeat (6) @(negedge clk);
        check_zero("post_rst_idle");
        run_sweep("after_rst", -1, -1, 0, 256, 256, 1, 256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
